rice_csr_hpm_counter_bank: RTL and testbench
============================================

RICE_CSR_HPM_COUNTER_BANK -- requirements
Module: rice_csr_hpm_counter_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent counters, range 1..32.
REQ-002 Parameter WIDTH, default 64: counter width, range XLEN+1..2*XLEN.
REQ-003 Parameter XLEN, default 32: CSR data width, 32 only.
REQ-004 Parameter INITIAL_VALUE, default '0: reset value of every counter, WIDTH bits.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset: i_clk (input, 1, rising-edge clock), then i_rst (input, 1, synchronous active-high reset).
REQ-006 i_write_valid  input  1  CSR write strobe.
REQ-007 i_write_channel  input  $clog2(CHANNELS) (min 1)  target channel of the write.
REQ-008 i_write_hi  input  1  0 selects bits [XLEN-1:0]; 1 selects bits [WIDTH-1:XLEN].
REQ-009 i_write_data  input  XLEN  write data.
REQ-010 i_write_mask  input  XLEN  per-bit write enable.
REQ-011 i_read_channel, i_read_hi  input  $clog2(CHANNELS), 1  read select.
REQ-012 o_read_data  output  XLEN  registered read data, zero-extended for the high half.
REQ-013 i_inhibit  input  CHANNELS  per-channel count inhibit.
REQ-014 i_event  input  CHANNELS  per-channel increment request, one per cycle.
REQ-015 o_count  output  CHANNELS x WIDTH  live counter values.
REQ-016 o_wrap  output  CHANNELS  one-cycle pulse when a counter wraps.

Function
REQ-017 A channel SHALL increment by 1 on a cycle with i_event=1, i_inhibit=0 and no write to that channel.
REQ-018 A write SHALL replace only the masked bits of the selected half: new = (data & mask) | (old & ~mask); for the high half, only bits above WIDTH-XLEN-1 are ignored.
REQ-019 A write with i_write_mask=0 SHALL be a no-op but SHALL still suppress that channel's increment in that cycle.
REQ-020 A write SHALL take priority over an increment on the same channel; that increment is dropped, not deferred.
REQ-021 A write SHALL NOT affect any other channel; other channels count normally in the same cycle.
REQ-022 Increment from all-ones SHALL wrap to zero and pulse o_wrap for that channel in the following cycle.
REQ-023 A write that yields all-ones SHALL NOT pulse o_wrap.
REQ-024 o_read_data SHALL show the selected half one cycle after the select, sampled before any same-cycle update.
REQ-025 Out-of-range i_write_channel SHALL be ignored; out-of-range i_read_channel SHALL read zero.

Reset
REQ-026 While i_rst=1: every counter SHALL be INITIAL_VALUE; o_read_data, o_wrap and overflow state SHALL be 0.
REQ-027 i_rst SHALL override any same-cycle write or event; the first count occurs on the first cycle with i_rst=0.

Configuration
REQ-028 With RICE_HPM_OVERFLOW_IRQ_EN defined, the block SHALL add input i_ovf_clear (CHANNELS) and outputs o_ovf (CHANNELS, sticky, set on wrap) and o_irq (1, OR of o_ovf).
REQ-029 Under that macro, o_ovf SHALL rise in the same cycle as o_wrap; i_ovf_clear clears it; set SHALL win over a same-cycle clear.
REQ-030 Without RICE_HPM_OVERFLOW_IRQ_EN, those ports and their state SHALL NOT exist.

Structure
REQ-031 Package rice_hpm_pkg SHALL hold RICE_HPM_MAX_CHANNELS and the type rice_hpm_half_e (LO/HI).
REQ-032 One sub-module, rice_hpm_counter_channel, SHALL be instantiated CHANNELS times; it holds one counter, its write merge, its increment and its wrap detection.

Verification
REQ-033 Reset, then i_event=1 for 10 cycles on channel 0 -> o_count[0]=10; other channels stay 0.
REQ-034 Preload channel 1 to 0xFFFF_FFFF via lo/hi writes with WIDTH=64, then 1 event -> 0x1_0000_0000 with no o_wrap; preload all-ones, then 1 event -> 0 and o_wrap[1] pulses once.
REQ-035 Write lo of channel 2 with data 0xAAAA_5555, mask 0x0000_FFFF, same cycle as an event -> low bits 0x5555 and upper bits unchanged, with no increment.
REQ-036 i_inhibit[3]=1 with continuous events -> count frozen; release -> resumes the next cycle.
REQ-037 With RICE_HPM_OVERFLOW_IRQ_EN defined, a wrap and i_ovf_clear in the same cycle -> o_ovf=1 and o_irq=1; a later clear -> both 0.
REQ-038 Read select of channel 0 hi on cycle N -> o_read_data on cycle N+1 equals the high half as of cycle N, and an asserted i_rst forces it to 0.

Source files
------------

// File: rtl/rice_hpm_pkg.sv
// Shared types and constants for the HPM counter bank.
// Overflow/IRQ support is enabled by defining RICE_HPM_OVERFLOW_IRQ_EN.
package rice_hpm_pkg;

  localparam int unsigned RICE_HPM_MAX_CHANNELS = 32;

  typedef enum logic {
    LO = 1'b0,
    HI = 1'b1
  } rice_hpm_half_e;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned rice_hpm_idx_width(input int unsigned channels);
    int unsigned n;
    n = (channels > RICE_HPM_MAX_CHANNELS) ? RICE_HPM_MAX_CHANNELS : channels;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rice_hpm_counter_channel.sv
// One HPM counter: masked half-word CSR write, gated increment and wrap detect.
// Sticky overflow flag exists only when RICE_HPM_OVERFLOW_IRQ_EN is defined.
module rice_hpm_counter_channel
  import rice_hpm_pkg::*;
#(
  parameter int unsigned      WIDTH         = 64,
  parameter int unsigned      XLEN          = 32,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  rice_hpm_half_e   wr_half_i,
  input  logic [XLEN-1:0]  wr_data_i,
  input  logic [XLEN-1:0]  wr_mask_i,
  input  logic             event_i,
  input  logic             inhibit_i,
`ifdef RICE_HPM_OVERFLOW_IRQ_EN
  input  logic             ovf_clear_i,
  output logic             ovf_o,
`endif
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o
);

  localparam int unsigned HiW = WIDTH - XLEN;

  logic [WIDTH-1:0] count_d, count_q;
  logic             wrap_d, wrap_q;

  // A write owns the channel for the cycle: any coincident event is dropped.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (wr_en_i) begin
      if (wr_half_i == HI) begin
        count_d[WIDTH-1:XLEN] = (wr_data_i[HiW-1:0] & wr_mask_i[HiW-1:0]) |
                                (count_q[WIDTH-1:XLEN] & ~wr_mask_i[HiW-1:0]);
      end else begin
        count_d[XLEN-1:0] = (wr_data_i & wr_mask_i) | (count_q[XLEN-1:0] & ~wr_mask_i);
      end
    end else if (event_i && !inhibit_i) begin
      count_d = count_q + WIDTH'(1);
      wrap_d  = &count_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= INITIAL_VALUE;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = wrap_q;

`ifdef RICE_HPM_OVERFLOW_IRQ_EN
  logic ovf_d, ovf_q;

  // Set wins over a same-cycle clear so a fresh wrap is never lost.
  always_comb begin
    ovf_d = (ovf_q & ~ovf_clear_i) | wrap_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`endif

endmodule

// File: rtl/rice_csr_hpm_counter_bank.sv
// Bank of CHANNELS hardware performance counters with a CSR write/read port.
// Define RICE_HPM_OVERFLOW_IRQ_EN to add sticky overflow flags and an IRQ.
module rice_csr_hpm_counter_bank
  import rice_hpm_pkg::*;
#(
  parameter int unsigned      CHANNELS      = 4,
  parameter int unsigned      WIDTH         = 64,
  parameter int unsigned      XLEN          = 32,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0,
  localparam int unsigned     ChW           = rice_hpm_idx_width(CHANNELS)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_write_valid,
  input  logic [ChW-1:0]                 i_write_channel,
  input  logic                           i_write_hi,
  input  logic [XLEN-1:0]                i_write_data,
  input  logic [XLEN-1:0]                i_write_mask,
  input  logic [ChW-1:0]                 i_read_channel,
  input  logic                           i_read_hi,
  output logic [XLEN-1:0]                o_read_data,
  input  logic [CHANNELS-1:0]            i_inhibit,
  input  logic [CHANNELS-1:0]            i_event,
  output logic [CHANNELS-1:0][WIDTH-1:0] o_count,
  output logic [CHANNELS-1:0]            o_wrap
`ifdef RICE_HPM_OVERFLOW_IRQ_EN
  ,
  input  logic [CHANNELS-1:0]            i_ovf_clear,
  output logic [CHANNELS-1:0]            o_ovf,
  output logic                           o_irq
`endif
);

  localparam int unsigned HiW = WIDTH - XLEN;

  logic [CHANNELS-1:0] wr_en;
  logic [XLEN-1:0]     read_data_d, read_data_q;
  rice_hpm_half_e      wr_half;

  assign wr_half = rice_hpm_half_e'(i_write_hi);

  // Out-of-range channel numbers match no channel, so writes vanish.
  always_comb begin
    wr_en = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      wr_en[c] = i_write_valid && (i_write_channel == ChW'(c));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    rice_hpm_counter_channel #(
      .WIDTH         (WIDTH),
      .XLEN          (XLEN),
      .INITIAL_VALUE (INITIAL_VALUE)
    ) u_chan (
      .clk_i       (i_clk),
      .rst_i       (i_rst),
      .wr_en_i     (wr_en[g]),
      .wr_half_i   (wr_half),
      .wr_data_i   (i_write_data),
      .wr_mask_i   (i_write_mask),
      .event_i     (i_event[g]),
      .inhibit_i   (i_inhibit[g]),
`ifdef RICE_HPM_OVERFLOW_IRQ_EN
      .ovf_clear_i (i_ovf_clear[g]),
      .ovf_o       (o_ovf[g]),
`endif
      .count_o     (o_count[g]),
      .wrap_o      (o_wrap[g])
    );
  end

  // Reads see the counters before this cycle's update; unknown channels read zero.
  always_comb begin
    read_data_d = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (i_read_channel == ChW'(c)) begin
        if (rice_hpm_half_e'(i_read_hi) == HI) begin
          read_data_d[HiW-1:0] = o_count[c][WIDTH-1:XLEN];
        end else begin
          read_data_d = o_count[c][XLEN-1:0];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      read_data_q <= '0;
    end else begin
      read_data_q <= read_data_d;
    end
  end

  assign o_read_data = read_data_q;

`ifdef RICE_HPM_OVERFLOW_IRQ_EN
  assign o_irq = |o_ovf;
`endif

endmodule

// File: tb/tb_rice_csr_hpm_counter_bank.sv
// Self-checking bench: directed scenarios plus random traffic against a
// cycle-level arithmetic model of the counter bank.
module tb_rice_csr_hpm_counter_bank;

  localparam int unsigned CH = 4;

  logic                  clk = 1'b0;
  logic                  rst, wv, whi, rhi;
  logic [1:0]            wch, rch;
  logic [31:0]           wdata, wmask, rd;
  logic [CH-1:0]         inh, ev, wrap;
  logic [CH-1:0][63:0]   cnt;
`ifdef RICE_HPM_OVERFLOW_IRQ_EN
  logic [CH-1:0]         clr, ovf, m_ovf;
  logic                  irq;
`endif

  logic [63:0]           m_cnt [CH];
  logic [CH-1:0]         m_wrap;
  logic [31:0]           m_rd;
  int                    n_pass = 0;
  int                    n_total = 0;

  always #5 clk = ~clk;

  rice_csr_hpm_counter_bank #(
    .CHANNELS (CH),
    .WIDTH    (64),
    .XLEN     (32)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_write_valid   (wv),
    .i_write_channel (wch),
    .i_write_hi      (whi),
    .i_write_data    (wdata),
    .i_write_mask    (wmask),
    .i_read_channel  (rch),
    .i_read_hi       (rhi),
    .o_read_data     (rd),
    .i_inhibit       (inh),
    .i_event         (ev),
    .o_count         (cnt),
    .o_wrap          (wrap)
`ifdef RICE_HPM_OVERFLOW_IRQ_EN
    ,
    .i_ovf_clear     (clr),
    .o_ovf           (ovf),
    .o_irq           (irq)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Next-cycle expectations from the current inputs and the current model state.
  task automatic model_update();
    logic [63:0] ones;
    ones = '1;
    m_rd = rst ? 32'h0 : (rhi ? m_cnt[rch][63:32] : m_cnt[rch][31:0]);
    for (int c = 0; c < CH; c++) begin
      m_wrap[c] = 1'b0;
      if (rst) begin
        m_cnt[c] = 64'h0;
      end else if (wv && wch == 2'(c)) begin
        if (whi) m_cnt[c] = (m_cnt[c] & ~{wmask, 32'h0}) | {wdata & wmask, 32'h0};
        else     m_cnt[c] = (m_cnt[c] & ~{32'h0, wmask}) | {32'h0, wdata & wmask};
      end else if (ev[c] && !inh[c]) begin
        m_wrap[c] = (m_cnt[c] == ones);
        m_cnt[c]  = m_cnt[c] + 64'd1;
      end
    end
`ifdef RICE_HPM_OVERFLOW_IRQ_EN
    m_ovf = rst ? '0 : ((m_ovf & ~clr) | m_wrap);
`endif
  endtask

  task automatic compare_all();
    for (int c = 0; c < CH; c++) check($sformatf("count%0d", c), cnt[c], m_cnt[c]);
    check("wrap", 64'(wrap), 64'(m_wrap));
    check("read_data", 64'(rd), 64'(m_rd));
`ifdef RICE_HPM_OVERFLOW_IRQ_EN
    check("ovf", 64'(ovf), 64'(m_ovf));
    check("irq", 64'(irq), 64'(|m_ovf));
`endif
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic wr(input logic [1:0] ch, input logic hi, input logic [31:0] d,
                    input logic [31:0] m);
    wv = 1'b1; wch = ch; whi = hi; wdata = d; wmask = m;
    step();
    wv = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wv = 1'b0; wch = '0; whi = 1'b0; wdata = '0; wmask = '0;
    rch = '0; rhi = 1'b0; inh = '0; ev = '1;
`ifdef RICE_HPM_OVERFLOW_IRQ_EN
    clr = '0;
    m_ovf = '0;
`endif
    // Reset beats concurrent events.
    step();
    step();
    check("reset_cnt0", cnt[0], 64'h0);
    check("reset_rd", 64'(rd), 64'h0);

    // Ten events on channel 0 only.
    rst = 1'b0; ev = 4'b0001;
    repeat (10) step();
    check("ten_events_cnt0", cnt[0], 64'd10);
    check("ten_events_cnt1", cnt[1], 64'd0);
    ev = '0;

    // Carry from low to high half without a wrap, then a full wrap.
    wr(2'd1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wr(2'd1, 1'b1, 32'h0, 32'hFFFF_FFFF);
    ev = 4'b0010; step(); ev = '0;
    check("carry_cnt1", cnt[1], 64'h1_0000_0000);
    check("carry_nowrap", 64'(wrap[1]), 64'd0);
    wr(2'd1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wr(2'd1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("allones_nowrap", 64'(wrap[1]), 64'd0);
    ev = 4'b0010; step(); ev = '0;
    check("wrap_cnt1", cnt[1], 64'h0);
    check("wrap_pulse", 64'(wrap[1]), 64'd1);
    step();
    check("wrap_once", 64'(wrap[1]), 64'd0);

    // Masked low write with a coincident event: merge, no increment.
    wr(2'd2, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF);
    wr(2'd2, 1'b0, 32'h9ABC_DEF0, 32'hFFFF_FFFF);
    wv = 1'b1; wch = 2'd2; whi = 1'b0; wdata = 32'hAAAA_5555; wmask = 32'h0000_FFFF;
    ev = 4'b0100; step(); wv = 1'b0; ev = '0;
    check("masked_write_cnt2", cnt[2], 64'h1234_5678_9ABC_5555);

    // Zero-mask write still swallows the increment.
    wv = 1'b1; wch = 2'd2; wmask = '0; ev = 4'b0100; step(); wv = 1'b0; ev = '0;
    check("nomask_write_cnt2", cnt[2], 64'h1234_5678_9ABC_5555);

    // Inhibit freezes channel 3; release resumes on the next cycle.
    ev = 4'b1000; inh = 4'b1000;
    repeat (5) step();
    check("inhibit_frozen", cnt[3], 64'd0);
    inh = '0; step();
    check("inhibit_release1", cnt[3], 64'd1);
    step();
    check("inhibit_release2", cnt[3], 64'd2);
    ev = '0;

`ifdef RICE_HPM_OVERFLOW_IRQ_EN
    wr(2'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wr(2'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    ev = 4'b0001; clr = 4'b0001; step(); ev = '0;
    check("ovf_set_wins", 64'(ovf[0]), 64'd1);
    check("irq_set", 64'(irq), 64'd1);
    clr = '1; step(); clr = '0;
    check("ovf_cleared", 64'(ovf), 64'd0);
    check("irq_cleared", 64'(irq), 64'd0);
`endif

    // Registered read sees the pre-update value of the selected half.
    wr(2'd0, 1'b1, 32'hCAFE_F00D, 32'hFFFF_FFFF);
    rch = 2'd0; rhi = 1'b1; step();
    check("read_hi", 64'(rd), 64'hCAFE_F00D);
    wv = 1'b1; wch = 2'd0; whi = 1'b1; wdata = 32'h1111_1111; wmask = '1; step(); wv = 1'b0;
    check("read_old_value", 64'(rd), 64'hCAFE_F00D);
    step();
    check("read_new_value", 64'(rd), 64'h1111_1111);
    rst = 1'b1; step(); rst = 1'b0;
    check("read_reset", 64'(rd), 64'h0);

    // Random traffic biased toward all-ones data so wraps actually occur.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      wv  = ($urandom_range(0, 2) == 0);
      wch = 2'($urandom_range(0, 3));
      whi = 1'($urandom);
      case ($urandom_range(0, 3))
        0: wdata = $urandom;
        1: wdata = 32'hFFFF_FFFF;
        2: wdata = 32'hFFFF_FFFE;
        default: wdata = 32'h0;
      endcase
      case ($urandom_range(0, 3))
        0: wmask = $urandom;
        3: wmask = 32'h0;
        default: wmask = 32'hFFFF_FFFF;
      endcase
      ev  = 4'($urandom);
      inh = 4'($urandom) & 4'($urandom);
      rch = 2'($urandom_range(0, 3));
      rhi = 1'($urandom);
`ifdef RICE_HPM_OVERFLOW_IRQ_EN
      clr = 4'($urandom) & 4'($urandom) & 4'($urandom);
`endif
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
